alu_seq: RTL and testbench

- Parametrised, registered successor to the combinational 16-bit ripple ALU.
- Takes one operation per valid/ready handshake, encodes the opcode (no one-hot selects), and registers the result plus Z/N/C/V flags.
- Adds an iterative shift-add multiply, so some operations take more than one cycle.
- Sits between the register-file read stage and write-back in the datapath.

---
 rtl/alu_seq_pkg.sv | 30 +++
 rtl/alu_mul_seq.sv | 61 ++++++
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Opcodes, FSM state encoding and flag bit positions for alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : Iterative unsigned shift-add multiplier, one step per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   PRODUCT
);

    localparam logic [SHW:0] c_last = (SHW+1)'(WIDTH);

    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [SHW:0]       r_cnt;

    logic [WIDTH-1:0]   w_mcand;
    logic [2*WIDTH-1:0] w_base;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_step;

    // The start cycle already performs the first step so that the full
    // product is ready after WIDTH edges.
    always_comb begin
        w_mcand = START ? A : r_mcand;
        w_base  = START ? {{WIDTH{1'b0}}, B} : r_prod;
        w_sum   = {1'b0, w_base[2*WIDTH-1:WIDTH]} + (w_base[0] ? {1'b0, w_mcand} : '0);
        w_step  = {w_sum, w_base[WIDTH-1:1]};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
        end else if (START) begin
            r_mcand <= A;
            r_prod  <= w_step;
            r_cnt   <= {{SHW{1'b0}}, 1'b1};
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_prod <= w_step;
            r_cnt  <= r_cnt + {{SHW{1'b0}}, 1'b1};
        end
    end

    assign DONE    = (r_cnt == c_last);
    assign PRODUCT = r_prod;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered valid/ready ALU with Z/N/C/V flags; MUL is built
//               only when ALU_SEQ_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] R,
    output logic [3:0]       FLAGS,
    output logic             ERR,
    output logic             BUSY
);

    state_t           r_state;
    logic [WIDTH-1:0] r_res;
    logic [3:0]       r_flags;
    logic             r_err;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;
    logic [3:0]       w_flags;

    assign IN_READY  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && OUT_READY);
    assign w_accept  = IN_VALID && IN_READY;
    assign OUT_VALID = (r_state == ST_DONE);
    assign R         = r_res;
    assign FLAGS     = r_flags;
    assign ERR       = r_err;

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (OP)
            OP_ADD: begin
                w_sum = {1'b0, A} + {1'b0, B};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_NOT: w_res = ~A;
            OP_SHL: begin
                // Bit WIDTH of the widened shift is the last bit shifted out.
                w_sum = {1'b0, A} << B[SHW-1:0];
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            default: begin
`ifndef ALU_SEQ_MUL_EN
                w_err = 1'b1;
`endif
            end
        endcase

        w_flags = '0;
        if (!w_err) begin
            w_flags[FLG_Z] = (w_res == '0);
            w_flags[FLG_N] = w_res[WIDTH-1];
            w_flags[FLG_C] = w_c;
            w_flags[FLG_V] = w_v;
        end
    end

`ifdef ALU_SEQ_MUL_EN
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_mul_prod;
    logic [3:0]           w_mul_flags;

    assign w_mul_start = w_accept && (OP == OP_MUL);
    assign BUSY        = (r_state == ST_MUL);

    always_comb begin
        w_mul_flags        = '0;
        w_mul_flags[FLG_Z] = (w_mul_prod[WIDTH-1:0] == '0);
        w_mul_flags[FLG_N] = w_mul_prod[WIDTH-1];
        w_mul_flags[FLG_C] = |w_mul_prod[2*WIDTH-1:WIDTH];
    end

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_mul (
        .CLK     (CLK),
        .RST     (RST),
        .START   (w_mul_start),
        .A       (A),
        .B       (B),
        .DONE    (w_mul_done),
        .PRODUCT (w_mul_prod)
    );
`else
    assign BUSY = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_res   <= '0;
            r_flags <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (OP == OP_MUL) begin
                r_state <= ST_MUL;
            end else begin
`else
            begin
`endif
                r_state <= ST_DONE;
                r_res   <= w_res;
                r_flags <= w_flags;
                r_err   <= w_err;
            end
        end
`ifdef ALU_SEQ_MUL_EN
        else if ((r_state == ST_MUL) && w_mul_done) begin
            r_state <= ST_DONE;
            r_res   <= w_mul_prod[WIDTH-1:0];
            r_flags <= w_mul_flags;
            r_err   <= 1'b0;
        end
`endif
        else if ((r_state == ST_DONE) && OUT_READY) begin
            r_state <= ST_IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
    localparam bit c_mul_en = 1'b1;
`else
    localparam bit c_mul_en = 1'b0;
`endif

    logic        CLK, RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY, ERR, BUSY;
    logic [2:0]  OP;
    logic [15:0] A, B, R;
    logic [3:0]  FLAGS;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP(OP), .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .R(R), .FLAGS(FLAGS), .ERR(ERR), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference result {err, V, C, N, Z, r} from plain arithmetic.
    function automatic logic [20:0] calc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        c, v;
        logic [31:0] full;
        int          sa, sb, sr, sh;
        sa = $signed(a);
        sb = $signed(b);
        r = '0; c = 1'b0; v = 1'b0; sr = 0;
        case (op)
            3'd0: begin full = {16'h0, a} + {16'h0, b}; r = full[15:0]; c = full[16];
                        sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            3'd1: begin r = a - b; c = (a >= b);
                        sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin sh = int'(b[3:0]); r = a << sh; c = (sh == 0) ? 1'b0 : a[16-sh]; end
            default: begin
                if (!c_mul_en) return {1'b1, 4'b0000, 16'h0000};
                full = a * b; r = full[15:0]; c = (full[31:16] != 16'h0);
            end
        endcase
        return {1'b0, v, c, r[15], (r == 16'h0), r};
    endfunction

    // Transaction-level model: one result slot plus a multiply countdown.
    bit          m_valid;
    int          m_busy;
    logic [20:0] m_res, m_pend;

    function automatic bit model_ready();
        return (m_busy == 0) && (!m_valid || OUT_READY);
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_valid = 1'b0; m_busy = 0; m_res = '0; m_pend = '0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_valid = 1'b1; m_res = m_pend; end
        end else if (IN_VALID && model_ready()) begin
            if (OP == 3'd7 && c_mul_en) begin
                m_pend = calc(OP, A, B); m_busy = 16; m_valid = 1'b0;
            end else begin
                m_res = calc(OP, A, B); m_valid = 1'b1;
            end
        end else if (m_valid && OUT_READY) begin
            m_valid = 1'b0;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            check("rst_out_valid", OUT_VALID, 0);
            check("rst_busy", BUSY, 0);
            check("rst_r", R, 0);
            check("rst_flags", FLAGS, 0);
        end else begin
            check("in_ready", IN_READY, model_ready());
            check("out_valid", OUT_VALID, m_valid);
            check("busy", BUSY, m_busy > 0);
            if (m_valid) begin
                check("r", R, m_res[15:0]);
                check("flags", FLAGS, m_res[19:16]);
                check("err", ERR, m_res[20]);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bit rdy, acc;
        acc = 1'b0;
        IN_VALID = 1'b1; OP = op; A = a; B = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK); rdy = IN_READY;
            @(posedge CLK); #1;
            if (rdy) begin acc = 1'b1; break; end
        end
        IN_VALID = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    // Literal expectations: latency, busy cycles and the result itself.
    task automatic wait_result(input string name, input logic [15:0] er, input logic [3:0] ef,
                               input logic ee, input int elat, input int ebusy);
        int lat, nbusy;
        bit got;
        lat = 0; nbusy = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK); lat++;
            if (BUSY) nbusy++;
            if (OUT_VALID) begin got = 1'b1; break; end
        end
        if (!got) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_latency"}, lat, elat);
            check({name, "_busy_cycles"}, nbusy, ebusy);
            check({name, "_r"}, R, er);
            check({name, "_flags"}, FLAGS, ef);
            check({name, "_err"}, ERR, ee);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; OP = '0; A = '0; B = '0; OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("reset_in_ready", IN_READY, 1);
        check("reset_out_valid", OUT_VALID, 0);
        @(posedge CLK); #1;

        issue(3'd0, 16'h7FFF, 16'h0001); wait_result("add_ovf", 16'h8000, 4'b1010, 0, 1, 0);
        issue(3'd1, 16'h0005, 16'h0005); wait_result("sub_zero", 16'h0000, 4'b0101, 0, 1, 0);
        issue(3'd1, 16'h0000, 16'h0001); wait_result("sub_borrow", 16'hFFFF, 4'b0010, 0, 1, 0);
        if (c_mul_en) begin
            issue(3'd7, 16'd300, 16'd300); wait_result("mul", 16'h5F90, 4'b0100, 0, 17, 16);
        end else begin
            issue(3'd7, 16'd300, 16'd300); wait_result("mul_off", 16'h0000, 4'b0000, 1, 1, 0);
        end
        issue(3'd5, 16'h00FF, 16'h0000); wait_result("not", 16'hFF00, 4'b0010, 0, 1, 0);
        issue(3'd3, 16'h0000, 16'h0000); wait_result("or_zero", 16'h0000, 4'b0001, 0, 1, 0);

        // Stall the consumer, then hand over back-to-back.
        OUT_READY = 1'b0;
        issue(3'd4, 16'hF0F0, 16'hFF00); wait_result("xor", 16'h0FF0, 4'b0000, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("hold_r", R, 16'h0FF0);
            check("hold_in_ready", IN_READY, 0);
            check("hold_out_valid", OUT_VALID, 1);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b1; OP = 3'd2; A = 16'h1234; B = 16'h00FF; OUT_READY = 1'b1;
        @(negedge CLK); check("b2b_in_ready", IN_READY, 1);
        @(posedge CLK); #1 IN_VALID = 1'b0;
        @(negedge CLK);
        check("b2b_out_valid", OUT_VALID, 1);
        check("b2b_r", R, 16'h0034);
        @(posedge CLK); #1;

        issue(3'd6, 16'h8001, 16'h0001); wait_result("shl1", 16'h0002, 4'b0100, 0, 1, 0);
        issue(3'd6, 16'h8001, 16'h0010); wait_result("shl0", 16'h8001, 4'b0010, 0, 1, 0);
        issue(3'd6, 16'h0003, 16'h000F); wait_result("shl15", 16'h8000, 4'b0110, 0, 1, 0);

        // Reset in the middle of a multiply.
        issue(3'd7, 16'd300, 16'd300);
        repeat (4) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("midrst_out_valid", OUT_VALID, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_r", R, 0);
        check("midrst_flags", FLAGS, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK); check("post_rst_in_ready", IN_READY, 1);
        @(posedge CLK); #1;
        issue(3'd0, 16'd2, 16'd3); wait_result("add_after_rst", 16'h0005, 4'b0000, 0, 1, 0);

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
